// File: rtl/aes_pipe_scheduler_pkg.sv
// Shared types and constants for the AES pipeline scheduler.
package aes_pipe_scheduler_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] state_t;
    typedef logic [127:0] key_t;

    typedef enum logic {AES_ENC = 1'b0, AES_DEC = 1'b1} aes_mode_t;

    // Scheduler FSM encoding
    typedef logic [1:0] sched_state_t;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Pick the core output that matches the block's direction.
    function automatic state_t sel_core_out(input aes_mode_t mode, input state_t enc, input state_t dec);
        return (mode == AES_DEC) ? dec : enc;
    endfunction

endpackage

// File: rtl/aes_pipe_scheduler_if.sv
// Requester-side request bus and consumer-side response bus of the scheduler.
interface aes_pipe_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    import aes_pipe_scheduler_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_mode;
    state_t [NUM_REQ-1:0]          req_data;
    key_t [NUM_REQ-1:0]            req_key;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;

    logic                          rsp_valid;
    logic                          rsp_ready;
    state_t                        rsp_data;
    logic [ID_W-1:0]               rsp_id;
    logic [TAG_W-1:0]              rsp_tag;

    // Requesters and response consumer
    modport master (
        output req_valid, req_mode, req_data, req_key, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_tag
    );

    // Scheduler
    modport slave (
        input  req_valid, req_mode, req_data, req_key, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_tag
    );
endinterface

// File: rtl/aes_resp_fifo.sv
// Synchronous response FIFO; push and pop may coincide at any fill level.
module aes_resp_fifo #(
    parameter int  DEPTH = 16,
    parameter int  CNT_W = $clog2(DEPTH + 1),
    parameter type T     = logic
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  T                 wdata_i,
    input  logic             pop_i,
    output T                 rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;
    logic             full;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    // Head is forced to zero when empty so stale storage never shows on the outputs
    assign rdata_o = empty_o ? T'('0) : mem_q[rd_q];

    // Storage needs no reset: only entries covered by the count are ever visible
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // The issuer's credit check must make this unreachable
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full && !do_pop))
        else $error("push into full response FIFO");

endmodule

// File: rtl/aes_pipe_scheduler.sv
// Round-robin scheduler sharing one fixed-latency AES encoder/decoder pair
// between NUM_REQ requesters, with sideband tracking and a credited response FIFO.
module aes_pipe_scheduler
    import aes_pipe_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int LATENCY    = NUM_ROUNDS,
    parameter int FIFO_DEPTH = 16,
    parameter int TAG_W      = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    aes_pipe_scheduler_if.slave bus,
    output state_t              core_in_o,
    output key_t                core_key_o,
    input  state_t              enc_out_i,
    input  state_t              dec_out_i,
    input  logic                flush_i,
    output logic                flush_done_o,
    output logic                busy_o
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic             vld;
        aes_mode_t        mode;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } sched_tag_t;

    typedef struct packed {
        state_t           data;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } rsp_entry_t;

    logic [ID_W-1:0]         rr_q;
    logic                    win_vld;
    logic [ID_W-1:0]         win_id;
    logic                    grant;
    logic [NUM_REQ-1:0]      ready;
    logic [CNT_W-1:0]        inflight_q;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_empty;
    logic [SUM_W-1:0]        used;
    logic                    drained;
    sched_state_t            state_q;
    sched_state_t            state_d;
    sched_tag_t [LATENCY-1:0] sb_q;
    sched_tag_t              sb_in;
    sched_tag_t              sb_out;
    logic                    push;
    logic                    pop;
    rsp_entry_t              push_entry;
    rsp_entry_t              head;

    // Requester index k slots after base, wrapping at NUM_REQ
    function automatic logic [ID_W-1:0] rr_slot(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Round-robin pick: first valid requester at or after rr_q
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && bus.req_valid[rr_slot(rr_q, k)]) begin
                win_vld = 1'b1;
                win_id  = rr_slot(rr_q, k);
            end
        end
    end

    // Every in-flight block already owns a FIFO slot, since the cores cannot stall.
    // A flush request also blocks the grant in its own cycle so nothing slips in.
    assign used    = SUM_W'(fifo_cnt) + SUM_W'(inflight_q);
    assign grant   = win_vld && (used < SUM_W'(FIFO_DEPTH)) && (state_q == ST_RUN) && !flush_i;
    assign drained = (inflight_q == '0) && fifo_empty;

    // One-hot ready for the winner only
    always_comb begin
        ready         = '0;
        ready[win_id] = grant;
    end
    assign bus.req_ready = ready;

    assign core_in_o  = grant ? bus.req_data[win_id] : '0;
    assign core_key_o = grant ? bus.req_key[win_id]  : '0;

    // Pointer advances past the winner, and only when something was granted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    rr_q <= '0;
        else if (grant) rr_q <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end

    // Sideband rides alongside the core pipeline; the tail lines up with core output
    assign sb_in  = '{vld: grant, mode: aes_mode_t'(bus.req_mode[win_id]), id: win_id, tag: bus.req_tag[win_id]};
    assign sb_out = sb_q[LATENCY-1];

    // Shift the sideband every cycle; reset clears vld so stale core data is ignored
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q <= '0;
        end else begin
            sb_q[0] <= sb_in;
            for (int s = 1; s < LATENCY; s++) sb_q[s] <= sb_q[s-1];
        end
    end

    assign push       = sb_out.vld;
    assign push_entry = '{data: sel_core_out(sb_out.mode, enc_out_i, dec_out_i), id: sb_out.id, tag: sb_out.tag};

    // In-flight count tracks the vld bits inside the sideband
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
        end else begin
            case ({grant, push})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    aes_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W),
        .T     (rsp_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_data  = head.data;
    assign bus.rsp_id    = head.id;
    assign bus.rsp_tag   = head.tag;

    // RUN -> DRAIN on flush, DRAIN -> HALT once empty, HALT -> RUN when flush drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_i) state_d = ST_DRAIN;
            ST_DRAIN: if (drained) state_d = ST_HALT;
            ST_HALT:  if (!flush_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    assign flush_done_o = (state_q == ST_DRAIN) && drained;
    assign busy_o       = (inflight_q != '0) || !fifo_empty;

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Directed bench for aes_pipe_scheduler with behavioural fixed-latency cores.
module tb_aes_pipe_scheduler;
    import aes_pipe_scheduler_pkg::*;

    localparam int NUM_REQ    = 2;
    localparam int LATENCY    = NUM_ROUNDS;
    localparam int FIFO_DEPTH = 16;
    localparam int TAG_W      = 4;

    localparam state_t PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam key_t   K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam state_t CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct { int cyc; int id; } gr_t;
    typedef struct { int cyc; state_t data; int id; int tag; } rp_t;

    logic   clk;
    logic   rst_n;
    state_t core_in;
    key_t   core_key;
    state_t enc_out;
    state_t dec_out;
    logic   flush;
    logic   flush_done;
    logic   busy;

    int  checks   = 0;
    int  failures = 0;
    int  cnt      = 0;
    gr_t grants[$];
    rp_t pops[$];
    int  fd[$];
    int  nr [NUM_REQ];

    aes_pipe_scheduler_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

    aes_pipe_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus          (bus),
        .core_in_o    (core_in),
        .core_key_o   (core_key),
        .enc_out_i    (enc_out),
        .dec_out_i    (dec_out),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-ins: FIPS-197 known answer, otherwise distinct XOR mappings per direction
    function automatic state_t f_enc(input state_t d, input key_t k);
        if (k == K0 && d == PT0) return CT0;
        return d ^ k;
    endfunction

    function automatic state_t f_dec(input state_t d, input key_t k);
        if (k == K0 && d == CT0) return PT0;
        return ~(d ^ k);
    endfunction

    // LATENCY-deep core pipelines, no reset (stale data survives a scheduler reset)
    state_t enc_pipe [LATENCY];
    state_t dec_pipe [LATENCY];
    always @(posedge clk) begin
        enc_pipe[0] <= f_enc(core_in, core_key);
        dec_pipe[0] <= f_dec(core_in, core_key);
        for (int s = 1; s < LATENCY; s++) begin
            enc_pipe[s] <= enc_pipe[s-1];
            dec_pipe[s] <= dec_pipe[s-1];
        end
    end
    assign enc_out = enc_pipe[LATENCY-1];
    assign dec_out = dec_pipe[LATENCY-1];

    function automatic state_t mk_data(input int r, input int n);
        return {16'hA5A5, 16'(r), 32'(n), 64'h0123_4567_89ab_cdef};
    endfunction

    function automatic key_t mk_key(input int r);
        return {8{16'(r * 4099 + 17)}};
    endfunction

    function automatic logic [TAG_W-1:0] mk_tag(input int r, input int n);
        return TAG_W'(n * 2 + r);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Log the transfers that happen on the coming edge, then move to the next negedge
    task automatic cyc();
        if (|bus.req_ready) begin
            gr_t g;
            g.cyc = cnt;
            g.id  = 0;
            for (int r = 0; r < NUM_REQ; r++) if (bus.req_ready[r]) g.id = r;
            grants.push_back(g);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            rp_t p;
            p.cyc  = cnt;
            p.data = bus.rsp_data;
            p.id   = int'(bus.rsp_id);
            p.tag  = int'(bus.rsp_tag);
            pops.push_back(p);
        end
        if (flush_done) fd.push_back(cnt);
        @(negedge clk);
        cnt++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            #1;
            cyc();
        end
    endtask

    task automatic clear_logs();
        grants.delete();
        pops.delete();
        fd.delete();
        for (int r = 0; r < NUM_REQ; r++) nr[r] = 0;
    endtask

    // Present the next block of every requester with the given modes; count grants
    task automatic drive_both(input logic [NUM_REQ-1:0] vld, input logic [NUM_REQ-1:0] mode);
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.req_data[r] = mk_data(r, nr[r]);
            bus.req_key[r]  = mk_key(r);
            bus.req_tag[r]  = mk_tag(r, nr[r]);
        end
        bus.req_mode  = mode;
        bus.req_valid = vld;
        #1;
        for (int r = 0; r < NUM_REQ; r++) if (bus.req_ready[r]) nr[r]++;
        cyc();
    endtask

    task automatic chk_resp(input string tag, input int i, input int r, input int n, input logic mode);
        state_t d;
        state_t e;
        d = mk_data(r, n);
        e = mode ? f_dec(d, mk_key(r)) : f_enc(d, mk_key(r));
        chk({tag, "_data"}, pops[i].data, e);
        chk({tag, "_id"},   pops[i].id,   r);
        chk({tag, "_tag"},  pops[i].tag,  mk_tag(r, n));
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = '0;
        bus.req_mode  = '0;
        bus.req_data  = '0;
        bus.req_key   = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_rsp_valid",  bus.rsp_valid, 0);
        chk("rst_busy",       busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_req_ready",  bus.req_ready, 0);
        chk("rst_core_in",    core_in, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        // 1: single encrypt from requester 0
        clear_logs();
        bus.rsp_ready   = 1'b1;
        bus.req_mode[0] = 1'b0;
        bus.req_data[0] = PT0;
        bus.req_key[0]  = K0;
        bus.req_tag[0]  = 4'd3;
        bus.req_valid   = 2'b01;
        #1;
        chk("t1_ready",    bus.req_ready, 2'b01);
        chk("t1_core_in",  core_in, PT0);
        chk("t1_core_key", core_key, K0);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("idle_core_in", core_in, 0);
        cyc();
        step(LATENCY + 4);
        chk("t1_npop", pops.size(), 1);
        if (pops.size() >= 1 && grants.size() >= 1) begin
            chk("t1_data", pops[0].data, CT0);
            chk("t1_id",   pops[0].id, 0);
            chk("t1_tag",  pops[0].tag, 3);
            chk("t1_lat",  pops[0].cyc - grants[0].cyc, LATENCY + 1);
        end

        // 2: decrypt the result on requester 1; rr pointer now favours requester 1
        clear_logs();
        bus.req_mode    = 2'b10;
        bus.req_data[1] = CT0;
        bus.req_key[1]  = K0;
        bus.req_tag[1]  = 4'd5;
        bus.req_data[0] = PT0;
        bus.req_valid   = 2'b11;
        #1;
        chk("t2_ready", bus.req_ready, 2'b10);
        cyc();
        bus.req_valid = '0;
        step(LATENCY + 4);
        chk("t2_npop", pops.size(), 1);
        if (pops.size() >= 1) begin
            chk("t2_data", pops[0].data, PT0);
            chk("t2_id",   pops[0].id, 1);
            chk("t2_tag",  pops[0].tag, 5);
        end

        // 3: both requesters valid for 8 cycles; req0 encrypts, req1 decrypts
        clear_logs();
        for (int i = 0; i < 8; i++) drive_both(2'b11, 2'b10);
        bus.req_valid = '0;
        step(LATENCY + 4);
        chk("t3_ngrant", grants.size(), 8);
        chk("t3_npop",   pops.size(), 8);
        if (grants.size() == 8 && pops.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t3_grant_id", grants[i].id, i % 2);
                chk_resp("t3", i, i % 2, i / 2, logic'(i % 2));
                chk("t3_pop_cyc", pops[i].cyc, pops[0].cyc + i);
            end
        end

        // 4: consumer stalled; only FIFO_DEPTH blocks may be admitted
        clear_logs();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) drive_both(2'b11, 2'b00);
        #1;
        chk("t4_stall_ready", bus.req_ready, 0);
        chk("t4_busy",        busy, 1);
        chk("t4_ngrant",      grants.size(), FIFO_DEPTH);
        chk("t4_nopop",       pops.size(), 0);
        cyc();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step(FIFO_DEPTH + 4);
        chk("t4_npop", pops.size(), FIFO_DEPTH);
        if (pops.size() == FIFO_DEPTH) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                chk_resp("t4", i, i % 2, i / 2, 1'b0);
                chk("t4_pop_cyc", pops[i].cyc, pops[0].cyc + i);
            end
        end
        drive_both(2'b00, 2'b00);
        bus.req_valid = 2'b01;
        #1;
        chk("t4_resume", bus.req_ready, 2'b01);
        cyc();
        bus.req_valid = '0;
        step(LATENCY + 4);

        // 5: flush with 5 blocks in flight while requester 0 keeps asking
        clear_logs();
        for (int i = 0; i < 5; i++) drive_both(2'b01, 2'b00);
        flush = 1'b1;
        #1;
        chk("t5_no_grant", bus.req_ready, 0);
        cyc();
        step(LATENCY + 8);
        chk("t5_ngrant", grants.size(), 5);
        chk("t5_npop",   pops.size(), 5);
        chk("t5_nfd",    fd.size(), 1);
        if (pops.size() == 5 && fd.size() >= 1) begin
            chk("t5_fd_cyc", fd[0], pops[4].cyc + 1);
            chk_resp("t5", 4, 0, 4, 1'b0);
        end
        #1;
        chk("t5_halt_ready", bus.req_ready, 0);
        cyc();
        flush = 1'b0;
        #1;
        chk("t5_halt_exit", bus.req_ready, 0);
        cyc();
        #1;
        chk("t5_resume", bus.req_ready, 2'b01);
        cyc();
        bus.req_valid = '0;
        step(LATENCY + 4);

        // 6: reset with 6 blocks issued, 2 already queued and 4 in flight
        clear_logs();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive_both(2'b10, 2'b00);
        bus.req_valid = '0;
        step(6);
        #1;
        chk("t6_pre_valid", bus.rsp_valid, 1);
        chk("t6_pre_busy",  busy, 1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.rsp_valid, 0);
        chk("t6_rst_busy",  busy, 0);
        cyc();
        step(1);
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        pops.delete();
        step(2 * LATENCY);
        chk("t6_nopop", pops.size(), 0);
        #1;
        chk("t6_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
